// File: rtl/umi_pkg.sv
// Shared UMI definitions.
// Holds the packet field layout and the command-write bit position, which the
// splitter and unpack blocks also use. It also holds the default starvation
// bound and the grant encoding used by the priority arbiter.
package umi_pkg;

  // Packet field layout (bit offsets within the UW-wide packet)
  localparam int UMI_CMD_LSB       = 0;
  localparam int UMI_CMD_W         = 32;
  localparam int UMI_DSTADDR_LSB   = 32;
  localparam int UMI_SRCADDR_LSB   = 96;
  localparam int UMI_DATA_LSB      = 160;

  // Command bit that marks write traffic
  localparam int UMI_CMD_WRITE_BIT = 1;

  // Default bound on how long the low-priority requester may be starved
  localparam int UMI_ARB_STARVE_DEFAULT = 8;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_UMI0 = 2'd1,
    GRANT_UMI1 = 2'd2
  } umi_grant_e;

  function automatic logic umi_is_write(input logic [UMI_CMD_W-1:0] cmd);
    return cmd[UMI_CMD_WRITE_BIT];
  endfunction

endpackage

// File: rtl/umi_pipe_reg.sv
// UW-wide valid/ready output register.
// It registers one packet and holds it until downstream accepts it.
// 'load' tells the producer when a new packet can be written this cycle:
// either the register is empty, or its contents leave this cycle.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   in_valid          - write a new packet; only meaningful while load=1
//   in_packet         - packet to write
//   load              - register can accept a packet this cycle
//   out_valid         - registered packet valid
//   out_packet        - registered packet
//   out_ready         - downstream accepts out_packet
module umi_pipe_reg #(
  parameter int UW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [UW-1:0] in_packet,
  output logic          load,
  output logic          out_valid,
  output logic [UW-1:0] out_packet,
  input  logic          out_ready
);

  logic          valid_q, valid_d;
  logic [UW-1:0] packet_q, packet_d;

  assign load = ~valid_q | out_ready;

  always_comb begin
    valid_d  = valid_q;
    packet_d = packet_q;
    if (load) begin
      // When the register drains with nothing new, valid drops and the
      // stale packet is left in place. This avoids a wide mux on the data.
      valid_d = in_valid;
      if (in_valid) begin
        packet_d = in_packet;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      packet_q <= '0;
    end else begin
      valid_q  <= valid_d;
      packet_q <= packet_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_packet = packet_q;

endmodule

// File: rtl/umi_priority_arbiter.sv
// Two-input UMI merger.
// umi0 (write traffic) has strict priority over umi1 (read requests).
// A starvation counter forces a umi1 grant once umi1 has lost STARVE
// arbitrations in a row. The output is registered through umi_pipe_reg.
// in_ready depends combinationally on umi_out_ready.
// Optional: define UMI_ARBITER_STATS_EN to add handshake/force counters.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   umi0_in_valid/packet/ready       - high-priority requester
//   umi1_in_valid/packet/ready       - low-priority requester
//   umi_out_valid/packet/ready       - shared registered output channel
//   stat_grant0/stat_grant1/stat_force (UMI_ARBITER_STATS_EN only)
module umi_priority_arbiter
  import umi_pkg::*;
#(
  parameter int AW     = 64,
  parameter int UW     = 256,
  parameter int STARVE = UMI_ARB_STARVE_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi0_in_valid,
  input  logic [UW-1:0] umi0_in_packet,
  output logic          umi0_in_ready,
  input  logic          umi1_in_valid,
  input  logic [UW-1:0] umi1_in_packet,
  output logic          umi1_in_ready,
  output logic          umi_out_valid,
  output logic [UW-1:0] umi_out_packet,
  input  logic          umi_out_ready
`ifdef UMI_ARBITER_STATS_EN
  ,
  output logic [31:0]   stat_grant0,
  output logic [31:0]   stat_grant1,
  output logic [15:0]   stat_force
`endif
);

  logic          load;
  logic          force_grant;
  umi_grant_e    grant;
  logic          sel_valid;
  logic [UW-1:0] sel_packet;

  // AW is carried only for interface consistency with other UMI blocks.
  // No address field is decoded here.
  if (AW > UW) begin : g_aw_wider_than_packet
  end

  // Grants are only issued when the output register can take a packet.
  // This is why in_ready already includes load.
  always_comb begin
    grant = GRANT_NONE;
    if (load) begin
      if (force_grant && umi1_in_valid) begin
        grant = GRANT_UMI1;
      end else if (umi0_in_valid) begin
        grant = GRANT_UMI0;
      end else if (umi1_in_valid) begin
        grant = GRANT_UMI1;
      end
    end
  end

  assign umi0_in_ready = (grant == GRANT_UMI0);
  assign umi1_in_ready = (grant == GRANT_UMI1);
  assign sel_valid     = umi0_in_ready | umi1_in_ready;
  assign sel_packet    = umi1_in_ready ? umi1_in_packet : umi0_in_packet;

  umi_pipe_reg #(.UW(UW)) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (sel_valid),
    .in_packet  (sel_packet),
    .load       (load),
    .out_valid  (umi_out_valid),
    .out_packet (umi_out_packet),
    .out_ready  (umi_out_ready)
  );

  if (STARVE > 0) begin : g_starve
    localparam int             CW         = $clog2(STARVE + 1);
    localparam logic [CW-1:0]  STARVE_MAX = CW'(STARVE);

    logic [CW-1:0] count_q, count_d;

    // The counter only moves on cycles where umi0 actually wins.
    // While the output is stalled (load=0) there are no grants, so the
    // counter holds: back-pressure does not count as starvation.
    always_comb begin
      count_d = count_q;
      if (!umi1_in_valid || umi1_in_ready) begin
        count_d = '0;
      end else if (umi0_in_ready && (count_q != STARVE_MAX)) begin
        count_d = count_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign force_grant = (count_q == STARVE_MAX);
  end else begin : g_strict
    assign force_grant = 1'b0;
  end

`ifdef UMI_ARBITER_STATS_EN
  logic [31:0] grant0_cnt_q;
  logic [31:0] grant1_cnt_q;
  logic [15:0] force_cnt_q;

  // Counters wrap naturally on overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
      force_cnt_q  <= '0;
    end else begin
      if (umi0_in_valid && umi0_in_ready) begin
        grant0_cnt_q <= grant0_cnt_q + 32'd1;
      end
      if (umi1_in_valid && umi1_in_ready) begin
        grant1_cnt_q <= grant1_cnt_q + 32'd1;
      end
      if (umi1_in_ready && force_grant) begin
        force_cnt_q <= force_cnt_q + 16'd1;
      end
    end
  end

  assign stat_grant0 = grant0_cnt_q;
  assign stat_grant1 = grant1_cnt_q;
  assign stat_force  = force_cnt_q;
`endif

endmodule

// File: tb/tb_umi_priority_arbiter.sv
// Bench for umi_priority_arbiter.
// The directed driver states the expected grant for every cycle and pushes
// the winning packet into a queue. A monitor pops and compares the queue on
// every output handshake. A second instance built with STARVE=0 is watched
// to make sure it never readies umi1 while umi0 is requesting.
module tb_umi_priority_arbiter;

  localparam int UW = 256;
  localparam int G_NONE = 0;
  localparam int G0     = 1;
  localparam int G1     = 2;

  logic          clk;
  logic          reset;
  logic          umi0_in_valid;
  logic [UW-1:0] umi0_in_packet;
  logic          umi1_in_valid;
  logic [UW-1:0] umi1_in_packet;
  logic          umi_out_ready;

  logic          umi0_in_ready, umi1_in_ready;
  logic          umi_out_valid;
  logic [UW-1:0] umi_out_packet;

  logic          s_umi0_in_ready, s_umi1_in_ready;
  logic          s_umi_out_valid;
  logic [UW-1:0] s_umi_out_packet;

`ifdef UMI_ARBITER_STATS_EN
  logic [31:0] stat_grant0, stat_grant1, s_stat_grant0, s_stat_grant1;
  logic [15:0] stat_force, s_stat_force;
`endif

  int total = 0;
  int bad   = 0;
  int idx0  = 0;
  int idx1  = 0;
  logic [UW-1:0] exp_q[$];

  umi_priority_arbiter #(.AW(64), .UW(UW), .STARVE(8)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .umi0_in_valid  (umi0_in_valid),
    .umi0_in_packet (umi0_in_packet),
    .umi0_in_ready  (umi0_in_ready),
    .umi1_in_valid  (umi1_in_valid),
    .umi1_in_packet (umi1_in_packet),
    .umi1_in_ready  (umi1_in_ready),
    .umi_out_valid  (umi_out_valid),
    .umi_out_packet (umi_out_packet),
    .umi_out_ready  (umi_out_ready)
`ifdef UMI_ARBITER_STATS_EN
    ,
    .stat_grant0    (stat_grant0),
    .stat_grant1    (stat_grant1),
    .stat_force     (stat_force)
`endif
  );

  umi_priority_arbiter #(.AW(64), .UW(UW), .STARVE(0)) u_dut_strict (
    .clk            (clk),
    .reset          (reset),
    .umi0_in_valid  (umi0_in_valid),
    .umi0_in_packet (umi0_in_packet),
    .umi0_in_ready  (s_umi0_in_ready),
    .umi1_in_valid  (umi1_in_valid),
    .umi1_in_packet (umi1_in_packet),
    .umi1_in_ready  (s_umi1_in_ready),
    .umi_out_valid  (s_umi_out_valid),
    .umi_out_packet (s_umi_out_packet),
    .umi_out_ready  (umi_out_ready)
`ifdef UMI_ARBITER_STATS_EN
    ,
    .stat_grant0    (s_stat_grant0),
    .stat_grant1    (s_stat_grant1),
    .stat_force     (s_stat_force)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [UW-1:0] mkpkt(input logic [7:0] src, input int idx);
    return {src, 216'd0, 32'(idx)};
  endfunction

  function automatic void check(input string name, input logic [UW-1:0] act,
                                input logic [UW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Output monitor: every accepted output packet must match the queue head.
  always @(negedge clk) begin
    if (!reset && umi_out_valid && umi_out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %h expected no packet", umi_out_packet);
      end else begin
        logic [UW-1:0] e;
        e = exp_q.pop_front();
        if (umi_out_packet !== e) begin
          bad++;
          $display("FAIL out_packet: got %h expected %h", umi_out_packet, e);
        end else begin
          $display("out pkt %h", umi_out_packet);
        end
      end
    end
  end

  // Strict-priority instance must never ready umi1 while umi0 requests.
  always @(negedge clk) begin
    if (!reset && umi0_in_valid) begin
      total++;
      if (s_umi1_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL strict_umi1_ready: got %b expected 0", s_umi1_in_ready);
      end
    end
  end

  // One arbitration cycle with a hand-computed expected grant.
  task automatic step(input logic iv0, input logic iv1, input logic irdy, input int exp_g);
    logic [UW-1:0] a, b;
    a = mkpkt(8'hA0, idx0);
    b = mkpkt(8'hB1, idx1);
    umi0_in_valid  = iv0;
    umi0_in_packet = a;
    umi1_in_valid  = iv1;
    umi1_in_packet = b;
    umi_out_ready  = irdy;
    @(negedge clk);
    check("umi0_in_ready", UW'(umi0_in_ready), UW'(exp_g == G0));
    check("umi1_in_ready", UW'(umi1_in_ready), UW'(exp_g == G1));
    if (exp_g == G0) begin
      exp_q.push_back(a);
      idx0++;
    end else if (exp_g == G1) begin
      exp_q.push_back(b);
      idx1++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    umi0_in_valid = 1'b0;
    umi1_in_valid = 1'b0;
    umi_out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", UW'(umi_out_valid), '0);
    check("rst_out_packet", umi_out_packet, '0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [UW-1:0] pkt_a;
    reset          = 1'b1;
    umi0_in_valid  = 1'b0;
    umi1_in_valid  = 1'b0;
    umi0_in_packet = '0;
    umi1_in_packet = '0;
    umi_out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    step(1'b0, 1'b0, 1'b1, G_NONE);

    // umi0 alone: P0..P9 stream through at full rate
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, G0);

    // Both valid: 8 umi0 grants, then a forced umi1 grant, three times
    for (int i = 0; i < 27; i++) step(1'b1, 1'b1, 1'b1, (i % 9 == 8) ? G1 : G0);

    // Stall with packet A held; counter must not move during the stall
    pkt_a = mkpkt(8'hA0, idx0);
    step(1'b1, 1'b1, 1'b1, G0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, G_NONE);
      check("stall_valid", UW'(umi_out_valid), UW'(1));
      check("stall_packet", umi_out_packet, pkt_a);
    end
    step(1'b1, 1'b1, 1'b1, G0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, G0);
    step(1'b1, 1'b1, 1'b1, G1);

    // Reach force, then umi1 drops valid: umi0 is granted normally
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, G0);
    step(1'b1, 1'b0, 1'b1, G0);
    step(1'b1, 1'b1, 1'b1, G0);

    // Reset while the output holds a packet
    step(1'b1, 1'b0, 1'b1, G0);
    step(1'b0, 1'b0, 1'b0, G_NONE);
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, (i == 8) ? G1 : G0);

    // umi1 alone, then drain
    step(1'b0, 1'b1, 1'b1, G1);
    step(1'b0, 1'b1, 1'b1, G1);
    step(1'b0, 1'b0, 1'b1, G_NONE);
    step(1'b0, 1'b0, 1'b1, G_NONE);
    check("queue_empty", UW'(exp_q.size()), '0);

`ifdef UMI_ARBITER_STATS_EN
    // 20 umi0 and 3 umi1 handshakes, 2 of the umi1 grants forced
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b1, (i % 9 == 8) ? G1 : G0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, G0);
    step(1'b0, 1'b1, 1'b1, G1);
    step(1'b0, 1'b0, 1'b1, G_NONE);
    step(1'b0, 1'b0, 1'b1, G_NONE);
    check("stat_grant0", UW'(stat_grant0), UW'(20));
    check("stat_grant1", UW'(stat_grant1), UW'(3));
    check("stat_force", UW'(stat_force), UW'(2));
    check("stats_queue_empty", UW'(exp_q.size()), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
